mcb_port_arbiter: RTL

- Shares one Spartan-6 MCB user port (cmd, wr and rd FIFOs, 32-bit) between two burst requesters, for example the DDR test engine and a host/DMA path.
- Round-robin grant per burst. The granted requester has exclusive use of the port until its burst completes.
- Sequences each burst as: write data pushed before the command; read command issued, then read data drained back to the owner.
- Sits between the requesters and the MCB port, after calibration.

---
 rtl/mcb_pkg.sv | 29 ++
 rtl/mcb_port_arbiter_rr_arb2.sv | 46 ++++
 rtl/mcb_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mcb_pkg.sv
// mcb_pkg: shared constants for the MCB user-port arbiter.
//   - MCB command instruction encodings (plain and auto-precharge).
//   - FSM state encodings (legacy-compatible localparam constants).
//   - Default widths matching a 32-bit Spartan-6 MCB user port.
package mcb_pkg;

  // Default widths for the MCB port and requester-side fields.
  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BL_W_DEF   = 6;
  localparam int unsigned INSTR_W    = 3;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned STATE_W    = 3;

  // MCB cmd_instr encodings.
  localparam logic [INSTR_W-1:0] INSTR_WR      = 3'b000;
  localparam logic [INSTR_W-1:0] INSTR_RD      = 3'b001;
  localparam logic [INSTR_W-1:0] INSTR_WR_AP   = 3'b010;
  localparam logic [INSTR_W-1:0] INSTR_RD_AP   = 3'b011;
  localparam logic [INSTR_W-1:0] INSTR_REFRESH = 3'b100;

  // Burst sequencer states.
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WDATA = 3'd1;
  localparam logic [STATE_W-1:0] ST_WCMD  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RCMD  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RDATA = 3'd4;

endpackage

// File: rtl/mcb_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   valid[1:0] : request lines
//   advance    : commit the current grant to the last-grant pointer
//   grant[1:0] : one-hot grant (combinational), zero when nothing is valid
//   last       : index of the most recently committed grant (1 after reset,
//                so requester 0 wins the first tie)
module rr_arb2
  import mcb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last
);

  logic last_q;
  logic last_d;

  // On a tie, favour the requester that did not win last time.
  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/mcb_port_arbiter.sv
// mcb_port_arbiter: shares one Spartan-6 MCB user port between two burst
// requesters with per-burst round-robin grant.
//   clk, rst            : clock, synchronous active-high reset
//   calib_done          : no new grant while low
//   reqN_*  (N=0,1)     : burst request (valid/ready/write/addr/bl),
//                         write data (wdata/wvalid/wready),
//                         read return (rdata/rvalid)
//   busy                : a burst is in progress
//   mcb_cmd_*           : command FIFO push
//   mcb_wr_*            : write FIFO push
//   mcb_rd_*            : read FIFO pop
// Build option: define MCB_AUTO_PRECHARGE_EN to issue the auto-precharge
// write/read instructions instead of the plain ones.
// Write bursts push all data before the command; reads issue the command
// then drain the read FIFO back to the owner. FIFO-side strobes are
// combinational on the FIFO flags so the port streams one word per cycle.
module mcb_port_arbiter
  import mcb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BL_W   = BL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [BL_W-1:0]   req0_bl,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_wvalid,
  output logic              req0_wready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [BL_W-1:0]   req1_bl,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_wvalid,
  output logic              req1_wready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,

  output logic              busy,

  output logic              mcb_cmd_en,
  output logic [2:0]        mcb_cmd_instr,
  output logic [5:0]        mcb_cmd_bl,
  output logic [29:0]       mcb_cmd_byte_addr,
  input  logic              mcb_cmd_full,

  output logic              mcb_wr_en,
  output logic [3:0]        mcb_wr_mask,
  output logic [31:0]       mcb_wr_data,
  input  logic              mcb_wr_full,

  output logic              mcb_rd_en,
  input  logic [31:0]       mcb_rd_data,
  input  logic              mcb_rd_empty
);

`ifdef MCB_AUTO_PRECHARGE_EN
  localparam logic [INSTR_W-1:0] WR_INSTR = INSTR_WR_AP;
  localparam logic [INSTR_W-1:0] RD_INSTR = INSTR_RD_AP;
`else
  localparam logic [INSTR_W-1:0] WR_INSTR = INSTR_WR;
  localparam logic [INSTR_W-1:0] RD_INSTR = INSTR_RD;
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [BL_W-1:0]    bl_q,    bl_d;
  logic [BL_W-1:0]    cnt_q,   cnt_d;

  logic [1:0]         arb_valid;
  logic               arb_advance;
  logic [1:0]         arb_grant;
  logic               owner;

  logic               sel_write;
  logic               sel_wvalid;
  logic [DATA_W-1:0]  sel_wdata;

  // The last-grant pointer only moves on a grant from IDLE, so it also
  // names the owner of the burst in flight.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .advance (arb_advance),
    .grant   (arb_grant),
    .last    (owner)
  );

  assign arb_valid   = calib_done ? {req1_valid, req0_valid} : 2'b00;
  assign arb_advance = (state_q == ST_IDLE);

  // Next-state and port strobes.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    bl_d              = bl_q;
    cnt_d             = cnt_q;

    req0_ready        = 1'b0;
    req1_ready        = 1'b0;
    req0_wready       = 1'b0;
    req1_wready       = 1'b0;
    req0_rvalid       = 1'b0;
    req1_rvalid       = 1'b0;
    req0_rdata        = '0;
    req1_rdata        = '0;
    mcb_cmd_en        = 1'b0;
    mcb_cmd_instr     = 3'b000;
    mcb_cmd_bl        = 6'd0;
    mcb_cmd_byte_addr = 30'd0;
    mcb_wr_en         = 1'b0;
    mcb_wr_mask       = 4'b0000;
    mcb_wr_data       = 32'd0;
    mcb_rd_en         = 1'b0;

    sel_write  = arb_grant[1] ? req1_write  : req0_write;
    sel_wvalid = owner        ? req1_wvalid : req0_wvalid;
    sel_wdata  = owner        ? req1_wdata  : req0_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_grant != 2'b00) begin
          req0_ready = arb_grant[0];
          req1_ready = arb_grant[1];
          addr_d     = arb_grant[1] ? req1_addr : req0_addr;
          bl_d       = arb_grant[1] ? req1_bl   : req0_bl;
          cnt_d      = '0;
          state_d    = sel_write ? ST_WDATA : ST_RCMD;
        end
      end

      ST_WDATA: begin
        mcb_wr_en = sel_wvalid && !mcb_wr_full;
        if (mcb_wr_en) begin
          mcb_wr_data = 32'(sel_wdata);
          req0_wready = !owner;
          req1_wready = owner;
          if (cnt_q == bl_q) begin
            state_d = ST_WCMD;
          end else begin
            cnt_d = cnt_q + BL_W'(1);
          end
        end
      end

      ST_WCMD: begin
        if (!mcb_cmd_full) begin
          mcb_cmd_en        = 1'b1;
          mcb_cmd_instr     = WR_INSTR;
          mcb_cmd_bl        = 6'(bl_q);
          mcb_cmd_byte_addr = 30'(addr_q);
          state_d           = ST_IDLE;
        end
      end

      ST_RCMD: begin
        if (!mcb_cmd_full) begin
          mcb_cmd_en        = 1'b1;
          mcb_cmd_instr     = RD_INSTR;
          mcb_cmd_bl        = 6'(bl_q);
          mcb_cmd_byte_addr = 30'(addr_q);
          cnt_d             = '0;
          state_d           = ST_RDATA;
        end
      end

      ST_RDATA: begin
        mcb_rd_en = !mcb_rd_empty;
        if (mcb_rd_en) begin
          req0_rvalid = !owner;
          req1_rvalid = owner;
          if (owner) begin
            req1_rdata = DATA_W'(mcb_rd_data);
          end else begin
            req0_rdata = DATA_W'(mcb_rd_data);
          end
          if (cnt_q == bl_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + BL_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      bl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule
